beta_clk_ctrl: RTL and testbench
================================

# beta_clk_ctrl

Programmable clock-enable controller for the Beta processor. Generates a one-cycle `tick` enable every `period_q` cycles of the board clock, supports run, halt and single-step control from the front panel or the CPU, and drives a heartbeat LED that toggles on every tick. It sits between the board clock and the processor's clock-enable input, so the CPU runs at a human-observable rate without clock gating.

## Interface
- `CNT_W`, 32: width of the period register and cycle counter.
- `DEFAULT_PERIOD`, 30000000: reset value of `period_q`, in clk cycles.
- `MIN_PERIOD`, 2: smallest legal period; smaller writes are clamped to this value.

Ports:
- `clk`  in  1  board clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `mode_run`  in  1  level; high requests free-running ticks.
- `step_req`  in  1  single-step request; acts on its rising edge, detected internally against the previous-cycle sample.
- `halt_req`  in  1  one-cycle pulse from the CPU (HALT decode).
- `period_wr`  in  1  write strobe for `period_din`.
- `period_din`  in  CNT_W  new period in cycles.
- `tick`  out  1  registered, one-cycle CPU clock enable.
- `led`  out  1  heartbeat; toggles on every `tick`.
- `running`  out  1  high while in state RUN.
- `period_q`  out  CNT_W  current period.

## Operation
- States: IDLE, RUN, STEP. STEP exists only with the single-step feature compiled in.
- `halt_lock` flag:
  - Set by `halt_req` in any state.
  - Cleared in any cycle where `mode_run` = 0.
  - While it is set, IDLE→RUN is blocked.
- IDLE:
  - `count` is held at 0 and `tick` = 0.
  - If `mode_run`=1 and `halt_lock`=0, go to RUN.
  - Otherwise, a `step_req` rising edge goes to STEP. This is allowed even while `halt_lock` is set.
  - If a run request and a step edge arrive in the same cycle, RUN wins and the step is dropped.
- RUN:
  - If `count` == `period_q`−1: `count`←0 and `tick`←1.
  - Otherwise `count`←`count`+1 and `tick`←0.
  - `halt_req`=1 or `mode_run`=0: go to IDLE with `count`←0 and `tick`←0. Halt wins even on a terminal-count cycle, so no tick is issued.
  - `step_req` is ignored.
- STEP: `tick`←1 for exactly one cycle, then go to IDLE.
- `led` ← ~`led` on every cycle where `tick` is registered high.
- Period write:
  - `period_q` ← max(`period_din`, `MIN_PERIOD`), and `count`←0 in the same edge.
  - That edge produces no tick.
  - The state is unchanged.
  - `period_wr` takes priority over the terminal-count tick.
- Counter arithmetic is unsigned, CNT_W bits. The comparison is always against `period_q`−1, so the counter never wraps past it.

## Timing
- Reset values: state IDLE, `count` 0, `tick` 0, `led` 0, `running` 0, `halt_lock` 0, `period_q` DEFAULT_PERIOD.
  - Reset is asynchronous and active-low, and also applies mid-operation.
- Run start: if edge k enters RUN, `running`=1 after edge k.
  - The first `tick` is high after edge k+N, where N = `period_q`.
  - Subsequent ticks follow every N cycles, each lasting exactly 1 cycle.
- Halt: `halt_req` sampled at edge k puts the block in IDLE and clears `running` after edge k.
- Step: a `step_req` rising edge sampled at edge k enters STEP.
  - `tick`=1 after edge k+1.
  - The block is back in IDLE after edge k+2.
  - Holding `step_req` high yields only one step.
- Period write at edge k: the next tick is N_new cycles after edge k.

## Configuration
- `BETA_CLK_STEP_EN` defined: the STEP state and `step_req` edge detect are present, as described above.
- Not defined:
  - STEP and the edge-detect register are removed.
  - `step_req` is ignored.
  - `tick` is produced only in RUN.

## Test plan
DEFAULT_PERIOD is overridden to 5 for simulation.
- Reset release with `mode_run`=1 held → `running`=1 after the first edge; `tick` pulses every 5 cycles; `led` toggles 0→1→0 over two ticks.
- RUN with `halt_req` pulsed on a terminal-count cycle → no tick, IDLE, `running`=0.
  - Continuing to hold `mode_run`=1 keeps the block in IDLE.
  - Dropping `mode_run` for 1 cycle and then reasserting it restarts ticking after 5 cycles.
- IDLE with `step_req` held high for 10 cycles → exactly one `tick`, 2 cycles after the rising edge.
  - Without `BETA_CLK_STEP_EN`, no tick at all.
- Write `period_din`=1 → `period_q`=2; ticks every 2 cycles. Write 8 mid-count → count restarts; the next tick is 8 cycles after the write.
- `rst` asserted mid-RUN while `tick`=1 → `tick`, `led` and `running` are 0 immediately; `period_q` returns to 5.
- `mode_run` and a `step_req` edge in the same IDLE cycle → RUN entered; no step tick; the first tick comes after 5 cycles.

Source files
------------

// File: rtl/beta_clk_ctrl_if.sv
// beta_clk_ctrl_if: run/step/halt controls, period write port and clock-enable outputs of beta_clk_ctrl
interface beta_clk_ctrl_if #(parameter int CNT_W = 32);
    logic             mode_run;
    logic             step_req;
    logic             halt_req;
    logic             period_wr;
    logic [CNT_W-1:0] period_din;
    logic             tick;
    logic             led;
    logic             running;
    logic [CNT_W-1:0] period_q;
    modport master (output mode_run, step_req, halt_req, period_wr, period_din,
                    input tick, led, running, period_q);
    modport slave (input mode_run, step_req, halt_req, period_wr, period_din,
                   output tick, led, running, period_q);
endinterface

// File: rtl/beta_clk_ctrl.sv
// beta_clk_ctrl: programmable tick generator with run/halt/step control and heartbeat LED.
// Define BETA_CLK_STEP_EN to build in the STEP state and step_req rising-edge detect.
module beta_clk_ctrl #(
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 30000000,
    parameter int unsigned MIN_PERIOD     = 2
) (
    input logic            clk,
    input logic            rst,
    beta_clk_ctrl_if.slave bus
);
`ifdef BETA_CLK_STEP_EN
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             tick_q, tick_d;
    logic             led_q, led_d;
    logic             lock_q, lock_d;
`ifdef BETA_CLK_STEP_EN
    logic             step_prev_q;
    logic             step_edge;
    assign step_edge = bus.step_req && !step_prev_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) step_prev_q <= 1'b0;
        else      step_prev_q <= bus.step_req;
    end
`endif
    always_comb begin
        state_d  = state_q;
        count_d  = '0;
        tick_d   = 1'b0;
        period_d = period_q;
        lock_d   = bus.halt_req ? 1'b1 : (bus.mode_run ? lock_q : 1'b0);
        case (state_q)
            RUN: begin
                if (bus.halt_req || !bus.mode_run) state_d = IDLE;
                else if (count_q == period_q - 1'b1) tick_d = 1'b1;
                else count_d = count_q + 1'b1;
            end
`ifdef BETA_CLK_STEP_EN
            // first STEP cycle raises tick, second returns to IDLE
            STEP: begin
                tick_d  = !tick_q;
                state_d = tick_q ? IDLE : STEP;
            end
`endif
            default: begin
                if (bus.mode_run && !lock_q && !bus.halt_req) state_d = RUN;
`ifdef BETA_CLK_STEP_EN
                else if (step_edge) state_d = STEP;
`endif
            end
        endcase
        if (bus.period_wr) begin
            period_d = (bus.period_din < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : bus.period_din;
            count_d  = '0;
            tick_d   = 1'b0;
            state_d  = state_q;
        end
        led_d = led_q ^ tick_d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            tick_q   <= 1'b0;
            led_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
            lock_q   <= lock_d;
        end
    end
    assign bus.tick     = tick_q;
    assign bus.led      = led_q;
    assign bus.running  = (state_q == RUN);
    assign bus.period_q = period_q;
endmodule

// File: tb/tb_beta_clk_ctrl.sv
// tb_beta_clk_ctrl: directed checks of run, halt lock, step, period write and reset with a period of 5.
module tb_beta_clk_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    beta_clk_ctrl_if #(.CNT_W(32)) bus ();
    beta_clk_ctrl #(.CNT_W(32), .DEFAULT_PERIOD(5), .MIN_PERIOD(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.mode_run   = 1'b1;
        bus.step_req   = 1'b0;
        bus.halt_req   = 1'b0;
        bus.period_wr  = 1'b0;
        bus.period_din = '0;
        cyc();
        cyc();
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_led", 32'(bus.led), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_period", bus.period_q, 5);
        rst = 1'b1;
        cyc();
        chk("run_start", 32'(bus.running), 1);
        for (int i = 2; i <= 11; i++) begin
            cyc();
            chk("run_tick", 32'(bus.tick), (i == 6 || i == 11) ? 1 : 0);
            if (i == 6) chk("led_first", 32'(bus.led), 1);
            if (i == 11) chk("led_second", 32'(bus.led), 0);
        end
        for (int i = 12; i <= 15; i++) cyc();
        bus.halt_req = 1'b1;
        cyc();
        bus.halt_req = 1'b0;
        chk("halt_tick", 32'(bus.tick), 0);
        chk("halt_running", 32'(bus.running), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_lock", 32'(bus.running), 0);
        end
        bus.mode_run = 1'b0;
        cyc();
        bus.mode_run = 1'b1;
        cyc();
        chk("restart_running", 32'(bus.running), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("restart_tick", 32'(bus.tick), (i == 5) ? 1 : 0);
        end
        bus.mode_run = 1'b0;
        cyc();
        chk("stop_running", 32'(bus.running), 0);
        bus.step_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
`ifdef BETA_CLK_STEP_EN
            chk("step_tick", 32'(bus.tick), (i == 2) ? 1 : 0);
`else
            chk("step_tick", 32'(bus.tick), 0);
`endif
            chk("step_running", 32'(bus.running), 0);
        end
        bus.step_req = 1'b0;
        cyc();
        bus.mode_run = 1'b1;
        bus.step_req = 1'b1;
        cyc();
        chk("race_running", 32'(bus.running), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("race_tick", 32'(bus.tick), (i == 5) ? 1 : 0);
        end
        bus.step_req   = 1'b0;
        bus.period_wr  = 1'b1;
        bus.period_din = 32'd1;
        cyc();
        bus.period_wr = 1'b0;
        chk("clamp_period", bus.period_q, 2);
        chk("wr_tick", 32'(bus.tick), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("p2_tick", 32'(bus.tick), (i % 2 == 0) ? 1 : 0);
        end
        cyc();
        bus.period_wr  = 1'b1;
        bus.period_din = 32'd8;
        cyc();
        bus.period_wr = 1'b0;
        chk("wr8_period", bus.period_q, 8);
        chk("wr8_no_tick", 32'(bus.tick), 0);
        chk("wr8_running", 32'(bus.running), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("p8_tick", 32'(bus.tick), (i == 8) ? 1 : 0);
        end
        rst = 1'b0;
        #1;
        chk("arst_tick", 32'(bus.tick), 0);
        chk("arst_led", 32'(bus.led), 0);
        chk("arst_running", 32'(bus.running), 0);
        chk("arst_period", bus.period_q, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
